// File: rtl/cnn_pkg.sv
// Shared CNN-accelerator constants and the dense-1 sequencer state encoding.
package cnn_pkg;

    localparam int DENSE1_N        = 120;
    localparam int DENSE1_ADDR_W   = 7;
    localparam int DENSE1_PIPE_LAT = 2;
    localparam int DENSE1_TIMEOUT  = 255;
    localparam int DENSE1_TMO_W    = 8;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_WAIT   = 3'd1,
        ST_LAUNCH = 3'd2,
        ST_STREAM = 3'd3,
        ST_DRAIN  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } d1_state_t;

endpackage

// File: rtl/dense1_wr_pipe.sv
// Activation-buffer write path: delays accepted beats by the bias+sigmoid latency
// and walks the write address 0..N_NEURON-1.
module dense1_wr_pipe #(
    parameter int N_NEURON = 120,
    parameter int ADDR_W   = 7,
    parameter int PIPE_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              valid_in,
    input  logic              flush,
    input  logic              addr_clr,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr
);

    localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(N_NEURON - 1);

    logic [PIPE_LAT-1:0] vld_sr;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_sr <= '0;
        end else if (flush) begin
            vld_sr <= '0;
        end else begin
            vld_sr[0] <= valid_in;
            for (int i = 1; i < PIPE_LAT; i++) begin
                vld_sr[i] <= vld_sr[i-1];
            end
        end
    end

    assign wr_en = vld_sr[PIPE_LAT-1];

    // Wrapping at the last address keeps wr_addr inside the buffer even after a full frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_addr <= '0;
        end else if (addr_clr) begin
            wr_addr <= '0;
        end else if (wr_en) begin
            wr_addr <= (wr_addr == ADDR_LAST) ? '0 : wr_addr + 1'b1;
        end
    end

endmodule

// File: rtl/dense1_seq_ctrl.sv
// Dense-1 sequencer: launches the serializer, counts beats, drives activation-buffer
// writes and reports done/err to the layer FSM.
//
//  state  | meaning
//  IDLE   | waiting for start
//  WAIT   | waiting for sum_ready & out_buf_free
//  LAUNCH | ser_ena pulsed, waiting for frame start (timed)
//  STREAM | counting ser_valid beats (timed, overrun-checked)
//  DRAIN  | letting the write pipe empty
//  DONE   | one-cycle done pulse
//  ERR    | set sticky err, flush write pipe
module dense1_seq_ctrl
    import cnn_pkg::*;
#(
    parameter int N_NEURON = DENSE1_N,
    parameter int ADDR_W   = DENSE1_ADDR_W,
    parameter int PIPE_LAT = DENSE1_PIPE_LAT,
    parameter int TIMEOUT  = DENSE1_TIMEOUT
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic              sum_ready,
    input  logic              out_buf_free,
    input  logic              ser_frame_st,
    input  logic              ser_valid,
    input  logic              ser_frame_end,
    output logic              ser_ena,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int                TMO_W      = DENSE1_TMO_W;
    localparam int                DRN_W      = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;
    localparam logic [ADDR_W-1:0] BEAT_FULL  = ADDR_W'(N_NEURON);
    localparam logic [TMO_W-1:0]  TMO_MAX    = TMO_W'(TIMEOUT);
    localparam logic [DRN_W-1:0]  DRAIN_LOAD = DRN_W'(PIPE_LAT - 1);

    d1_state_t         state;
    d1_state_t         state_d;
    logic [ADDR_W-1:0] beat_cnt;
    logic [TMO_W-1:0]  tmo;
    logic [DRN_W-1:0]  drain_cnt;
    logic              overrun;
    logic              beat_acc;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_d;
        end
    end

    always_comb begin
        state_d  = state;
        overrun  = (state == ST_STREAM) && ser_valid && (beat_cnt == BEAT_FULL);
        beat_acc = (state == ST_STREAM) && ser_valid && !overrun && !abort;
        if (abort) begin
            state_d = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE:   if (start) state_d = ST_WAIT;
                ST_WAIT:   if (sum_ready && out_buf_free) state_d = ST_LAUNCH;
                ST_LAUNCH: begin
                    if (ser_frame_st)         state_d = ST_STREAM;
                    else if (tmo == TMO_MAX)  state_d = ST_ERR;
                end
                ST_STREAM: begin
                    // A beat landing with frame_end is still counted; only an overrun beat is refused.
                    if (overrun)                           state_d = ST_ERR;
                    else if (ser_frame_end)                state_d = ST_DRAIN;
                    else if (!ser_valid && tmo == TMO_MAX) state_d = ST_ERR;
                end
                ST_DRAIN: begin
                    if (drain_cnt == '0) begin
                        state_d = (beat_cnt == BEAT_FULL) ? ST_DONE : ST_ERR;
                    end
                end
                ST_DONE:   state_d = ST_IDLE;
                ST_ERR:    state_d = ST_IDLE;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt  <= '0;
            tmo       <= '0;
            drain_cnt <= '0;
            ser_ena   <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            err       <= 1'b0;
        end else begin
            if (state == ST_IDLE) begin
                beat_cnt <= '0;
            end else if (beat_acc) begin
                beat_cnt <= beat_cnt + 1'b1;
            end

            if (state != ST_LAUNCH && state != ST_STREAM) begin
                tmo <= '0;
            end else if (state == ST_STREAM && ser_valid) begin
                tmo <= '0;
            end else if (tmo != TMO_MAX) begin
                tmo <= tmo + 1'b1;
            end

            if (state != ST_DRAIN) begin
                drain_cnt <= DRAIN_LOAD;
            end else if (drain_cnt != '0) begin
                drain_cnt <= drain_cnt - 1'b1;
            end

            ser_ena <= (state == ST_WAIT) && (state_d == ST_LAUNCH);
            busy    <= (state_d != ST_IDLE);
            done    <= (state_d == ST_DONE);

            if (abort) begin
                err <= 1'b0;
            end else if (state == ST_IDLE && start) begin
                err <= 1'b0;
            end else if (state_d == ST_ERR) begin
                err <= 1'b1;
            end
        end
    end

    dense1_wr_pipe #(
        .N_NEURON (N_NEURON),
        .ADDR_W   (ADDR_W),
        .PIPE_LAT (PIPE_LAT)
    ) u_wr_pipe (
        .clk      (clk),
        .rst_n    (rst_n),
        .valid_in (beat_acc),
        .flush    (abort || (state_d == ST_ERR)),
        .addr_clr (state_d == ST_IDLE),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr)
    );

endmodule

// File: tb/tb_dense1_seq_ctrl.sv
// Directed bench for dense1_seq_ctrl with a write scoreboard keyed on address and cycle.
module tb_dense1_seq_ctrl;

    localparam int N  = 120;
    localparam int PL = 2;

    logic       clk = 1'b0;
    logic       rst_n, start, abort, sum_ready, out_buf_free;
    logic       ser_frame_st, ser_valid, ser_frame_end;
    logic       ser_ena, wr_en, busy, done, err;
    logic [6:0] wr_addr;

    dense1_seq_ctrl dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .abort         (abort),
        .sum_ready     (sum_ready),
        .out_buf_free  (out_buf_free),
        .ser_frame_st  (ser_frame_st),
        .ser_valid     (ser_valid),
        .ser_frame_end (ser_frame_end),
        .ser_ena       (ser_ena),
        .wr_en         (wr_en),
        .wr_addr       (wr_addr),
        .busy          (busy),
        .done          (done),
        .err           (err)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;
    int n_wr = 0, n_ena = 0, n_done = 0, last_wr_cyc = 0;

    typedef struct {
        int addr;
        int at;
    } exp_t;
    exp_t exp_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (wr_en === 1'b1) begin
            n_wr++;
            last_wr_cyc = cyc;
            if (exp_q.size() == 0) begin
                chk("wr_en_unexpected", 32'(wr_en), 0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", 32'(wr_addr), e.addr);
                chk("wr_latency_cycle", cyc, e.at);
            end
        end
        if (ser_ena === 1'b1) n_ena++;
        if (done === 1'b1) n_done++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Writes expected after cycle c are cancelled by a flush sampled at the end of cycle c.
    task automatic flush_after(input int c);
        while (exp_q.size() > 0 && exp_q[$].at > c) exp_q.pop_back();
    endtask

    task automatic begin_pass();
        start = 1; sum_ready = 1; out_buf_free = 1;
        tick();
        start = 0;
        chk("busy_after_start", 32'(busy), 1);
        chk("err_cleared_by_start", 32'(err), 0);
        tick();
        chk("ser_ena_pulse", 32'(ser_ena), 1);
    endtask

    // cut_kind: 0 none, 1 abort at beat cut_at, 2 async reset at beat cut_at
    task automatic run_frame(input int nbeats, input int cut_at, input int cut_kind, input int start_at);
        int d;
        ser_frame_st = 1;
        tick();
        ser_frame_st = 0;
        chk("ser_ena_single", 32'(ser_ena), 0);
        for (int b = 0; b < nbeats; b++) begin
            if ($urandom_range(0, 4) == 0) tick();
            if (b == cut_at && cut_kind == 1) begin
                abort = 1;
                d = cyc;
                tick();
                abort = 0;
                flush_after(d);
                chk("abort_idle", 32'(busy), 0);
                chk("abort_wr_en", 32'(wr_en), 0);
                chk("abort_err", 32'(err), 0);
                return;
            end
            if (b == cut_at && cut_kind == 2) begin
                rst_n = 0;
                #2;
                chk("async_rst_outputs", 32'({ser_ena, wr_en, wr_addr, busy, done, err}), 0);
                exp_q.delete();
                tick();
                tick();
                rst_n = 1;
                tick();
                return;
            end
            ser_valid     = 1;
            ser_frame_end = (b == nbeats - 1);
            start         = (b == start_at);
            if (b < N) exp_q.push_back('{b, cyc + PL});
            d = cyc;
            tick();
            ser_valid = 0; ser_frame_end = 0; start = 0;
            if (b == N) begin
                flush_after(d);
                chk("overrun_err", 32'(err), 1);
                return;
            end
        end
    endtask

    task automatic wait_end(input bit expect_done);
        for (int k = 0; k < 40; k++) begin
            tick();
            if (done === 1'b1 || err === 1'b1) break;
        end
        chk("end_done", 32'(done), 32'(expect_done));
        chk("end_err", 32'(err), 32'(!expect_done));
        if (expect_done) begin
            chk("done_after_last_wr", cyc - last_wr_cyc, 1);
            tick();
            chk("done_one_cycle", 32'(done), 0);
            chk("idle_after_done", 32'(busy), 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached before test end");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, e0, d0, s;
        rst_n = 0; start = 0; abort = 0; sum_ready = 0; out_buf_free = 0;
        ser_frame_st = 0; ser_valid = 0; ser_frame_end = 0;
        repeat (3) tick();
        chk("rst_ser_ena", 32'(ser_ena), 0);
        chk("rst_wr_en", 32'(wr_en), 0);
        chk("rst_wr_addr", 32'(wr_addr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_err", 32'(err), 0);
        rst_n = 1;
        tick();

        // T1 nominal
        w0 = n_wr; e0 = n_ena;
        begin_pass();
        run_frame(N, -1, 0, -1);
        wait_end(1);
        chk("t1_wr_count", n_wr - w0, N);
        chk("t1_ena_count", n_ena - e0, 1);
        chk("t1_queue_empty", exp_q.size(), 0);

        // T2 gating on out_buf_free
        e0 = n_ena;
        start = 1; sum_ready = 1; out_buf_free = 0;
        tick();
        start = 0;
        repeat (50) tick();
        chk("t2_no_ena_while_gated", n_ena - e0, 0);
        chk("t2_busy_while_gated", 32'(busy), 1);
        out_buf_free = 1;
        tick();
        chk("t2_ena_next_cycle", 32'(ser_ena), 1);
        run_frame(N, -1, 0, -1);
        wait_end(1);

        // T3 short frame
        w0 = n_wr; d0 = n_done;
        begin_pass();
        run_frame(N - 1, -1, 0, -1);
        wait_end(0);
        chk("t3_wr_count", n_wr - w0, N - 1);
        chk("t3_no_done", n_done - d0, 0);
        tick();
        chk("t3_err_sticky", 32'(err), 1);

        // T4a overrun
        begin_pass();
        run_frame(N + 1, -1, 0, -1);
        repeat (5) tick();
        chk("t4a_queue_empty", exp_q.size(), 0);
        chk("t4a_idle", 32'(busy), 0);
        chk("t4a_err_sticky", 32'(err), 1);

        // T4b frame_start never arrives
        begin_pass();
        s = cyc;
        for (int k = 0; k < 300; k++) begin
            tick();
            if (err === 1'b1) break;
        end
        chk("t4b_timeout_err", 32'(err), 1);
        chk("t4b_timeout_window", 32'((cyc - s >= 255) && (cyc - s <= 257)), 1);
        repeat (3) tick();

        // T5 abort mid-stream, then a clean pass from address 0
        begin_pass();
        run_frame(N, 60, 1, -1);
        repeat (4) tick();
        chk("t5_queue_empty", exp_q.size(), 0);
        w0 = n_wr;
        begin_pass();
        run_frame(N, -1, 0, -1);
        wait_end(1);
        chk("t5_wr_count", n_wr - w0, N);

        // T6 async reset mid-stream, start while busy, back-to-back passes
        begin_pass();
        run_frame(N, 30, 2, -1);
        d0 = n_done;
        begin_pass();
        run_frame(N, -1, 0, 10);
        wait_end(1);
        begin_pass();
        run_frame(N, -1, 0, -1);
        wait_end(1);
        chk("t6_two_done", n_done - d0, 2);
        chk("t6_queue_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
